// File: rtl/csa_accum_ctrl_pkg.sv
// Shared definitions for the carry-save accumulator controller.
//   W_DEF   : default datapath width
//   STATE_W : width of the controller state encoding
//   state_t : controller states (IDLE, ACCUM, RESOLVE, DONE)
package csa_accum_ctrl_pkg;

    localparam int W_DEF   = 10;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/csa_accum_ctrl_if.sv
// Operand-in / result-out handshake bundle for csa_accum_ctrl.
//   in_valid/in_ready/in_data/in_last : operand stream, in_last marks group end
//   out_valid/out_ready/out_data      : resolved result, modulo 2^W
// master = upstream/downstream side, slave = the accumulator.
interface csa_accum_ctrl_if
    import csa_accum_ctrl_pkg::*;
#(
    parameter int W = W_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/csa_accum_ctrl_csa_row.sv
// csa_row_w: one row of W full adders used as a 3:2 compressor.
//   x, y, z : three W-bit addends
//   s       : bitwise sum  (x ^ y ^ z)
//   c       : bitwise carry (majority), not yet shifted
module csa_row_w
    import csa_accum_ctrl_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    assign s = x ^ y ^ z;
    assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/csa_accum_ctrl.sv
// csa_accum_ctrl: accumulates a variable-length operand group in carry-save
// form (one operand per cycle), then resolves the sum/carry pair to binary
// and presents it on the output handshake.
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, aborts any group in flight
//   bus  : csa_accum_ctrl_if.slave operand/result handshake
//   busy : high in every state except IDLE
// Build option CSA_FAST_RESOLVE_EN: when defined, RESOLVE finishes in one
// cycle with a W-bit binary adder; otherwise the shared CSA row is iterated
// until the shifted carry vector is zero.
//
// state   | meaning
// IDLE    | waiting for the first operand of a group
// ACCUM   | folding further operands into (S, C)
// RESOLVE | propagating carries until C is exhausted
// DONE    | result held on out_data until out_ready
module csa_accum_ctrl
    import csa_accum_ctrl_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    csa_accum_ctrl_if.slave  bus,
    output logic             busy
);

    state_t       state_q, state_d;
    logic [W-1:0] s_q, c_q;
    logic [W-1:0] cs;
    logic [W-1:0] row_z, row_s, row_c;
    logic [W-1:0] out_data_q;
    logic         in_ready_c, out_valid_c, accept;
    logic         carry_msb_unused;

    // Carry out of the top bit falls off: arithmetic is modulo 2^W.
    assign cs               = {c_q[W-2:0], 1'b0};
    assign carry_msb_unused = c_q[W-1];

    // In RESOLVE the third input is zero, so the row just folds Cs into S.
    assign row_z = (state_q == ST_ACCUM) ? bus.in_data : '0;

    csa_row_w #(.W(W)) u_row (
        .x (s_q),
        .y (cs),
        .z (row_z),
        .s (row_s),
        .c (row_c)
    );

    assign accept        = bus.in_valid && in_ready_c;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy        = 1'b1;
        case (state_q)
            ST_IDLE: begin
                in_ready_c = 1'b1;
                busy       = 1'b0;
                if (accept) begin
                    state_d = bus.in_last ? ST_RESOLVE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                in_ready_c = 1'b1;
                if (accept && bus.in_last) begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
`ifdef CSA_FAST_RESOLVE_EN
                state_d = ST_DONE;
`else
                if (cs == '0) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            s_q        <= '0;
            c_q        <= '0;
            out_data_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        s_q <= bus.in_data;
                        c_q <= '0;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        s_q <= row_s;
                        c_q <= row_c;
                    end
                end
                ST_RESOLVE: begin
`ifdef CSA_FAST_RESOLVE_EN
                    out_data_q <= s_q + cs;
`else
                    if (cs == '0) begin
                        out_data_q <= s_q;
                    end else begin
                        s_q <= row_s;
                        c_q <= row_c;
                    end
`endif
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        s_q <= '0;
                        c_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
